// File: rtl/simon_pkg.sv
// Shared Simon 128/128 definitions: word/block sizes, decryption FSM states
// and the round function used by both the encryption and decryption rounds.
package simon_pkg;

    localparam int SIMON_WORD      = 64;
    localparam int SIMON_BLOCK     = 128;
    localparam int SIMON128_ROUNDS = 68;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } simon_dec_state_t;

    // f(v) = (rotl(v,1) & rotl(v,8)) ^ rotl(v,2), written as fixed rotations
    function automatic logic [SIMON_WORD-1:0] simon_f(input logic [SIMON_WORD-1:0] v);
        logic [SIMON_WORD-1:0] r1;
        logic [SIMON_WORD-1:0] r2;
        logic [SIMON_WORD-1:0] r8;
        r1 = {v[SIMON_WORD-2:0], v[SIMON_WORD-1]};
        r2 = {v[SIMON_WORD-3:0], v[SIMON_WORD-1:SIMON_WORD-2]};
        r8 = {v[SIMON_WORD-9:0], v[SIMON_WORD-1:SIMON_WORD-8]};
        return (r1 & r8) ^ r2;
    endfunction

endpackage

// File: rtl/simon_round_inv.sv
// Combinational Simon inverse round: undoes one encryption round
// (x, y) -> (y ^ f(x) ^ k, x) given the same round key k.
module simon_round_inv
    import simon_pkg::*;
(
    input  logic [SIMON_WORD-1:0] x,
    input  logic [SIMON_WORD-1:0] y,
    input  logic [SIMON_WORD-1:0] k,
    output logic [SIMON_WORD-1:0] x_next,
    output logic [SIMON_WORD-1:0] y_next
);

    assign x_next = y;
    assign y_next = x ^ simon_f(y) ^ k;

endmodule

// File: rtl/simon_dec_core.sv
// Iterative Simon 128/128 decryption core, one inverse round per cycle with
// round keys fetched in reverse order. Optional abort via SIMON_DEC_ABORT_EN.
module simon_dec_core
    import simon_pkg::*;
#(
    parameter int ROUNDS = SIMON128_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [SIMON_BLOCK-1:0] ct_i,
    output logic [6:0]             rk_idx_o,
    input  logic [SIMON_WORD-1:0]  kj_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [SIMON_BLOCK-1:0] pt_o,
    output logic                   busy_o
`ifdef SIMON_DEC_ABORT_EN
    ,
    input  logic                   abort_i
`endif
);

    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    simon_dec_state_t      state_r;
    logic [SIMON_WORD-1:0] x_r;
    logic [SIMON_WORD-1:0] y_r;
    logic [6:0]            idx_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  busy_r;
    logic [SIMON_WORD-1:0] x_next_s;
    logic [SIMON_WORD-1:0] y_next_s;
    logic                  abort_s;

`ifdef SIMON_DEC_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    simon_round_inv u_round (
        .x      (x_r),
        .y      (y_r),
        .k      (kj_i),
        .x_next (x_next_s),
        .y_next (y_next_s)
    );

    // Control FSM, round counter and x/y state; handshake flags are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            x_r         <= {SIMON_WORD{1'b0}};
            y_r         <= {SIMON_WORD{1'b0}};
            idx_r       <= 7'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid_i) begin
                        x_r        <= ct_i[SIMON_BLOCK-1:SIMON_WORD];
                        y_r        <= ct_i[SIMON_WORD-1:0];
                        idx_r      <= LAST_IDX;
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_s) begin
                        x_r        <= {SIMON_WORD{1'b0}};
                        y_r        <= {SIMON_WORD{1'b0}};
                        idx_r      <= 7'd0;
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        x_r <= x_next_s;
                        y_r <= y_next_s;
                        if (idx_r == 7'd0) begin
                            state_r     <= DONE;
                            busy_r      <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r - 7'd1;
                        end
                    end
                end
                DONE: begin
                    // Abort takes priority over a simultaneous output handshake
                    if (abort_s) begin
                        x_r         <= {SIMON_WORD{1'b0}};
                        y_r         <= {SIMON_WORD{1'b0}};
                        idx_r       <= 7'd0;
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end else if (out_ready_i) begin
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    x_r         <= {SIMON_WORD{1'b0}};
                    y_r         <= {SIMON_WORD{1'b0}};
                    idx_r       <= 7'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign busy_o      = busy_r;
    assign rk_idx_o    = idx_r;
    assign pt_o        = {x_r, y_r};

endmodule

// File: tb/tb_simon_dec_core.sv
// Self-checking bench for simon_dec_core: known answer, random round trips
// against a Simon encryption/key-schedule model, backpressure and reset.
module tb_simon_dec_core;

    localparam int NR = 68;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct_in;
    logic [6:0]   rk_idx;
    logic [63:0]  kj;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt_out;
    logic         busy;
`ifdef SIMON_DEC_ABORT_EN
    logic         abort;
`endif

    logic [63:0] rk_tbl [0:127];
    int n_tests;
    int n_fail;

    simon_dec_core dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ct_i        (ct_in),
        .rk_idx_o    (rk_idx),
        .kj_i        (kj),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pt_o        (pt_out),
        .busy_o      (busy)
`ifdef SIMON_DEC_ABORT_EN
        ,
        .abort_i     (abort)
`endif
    );

    // External key store: combinational lookup by requested index
    assign kj = rk_tbl[rk_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotl64(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] ff(input logic [63:0] v);
        return (rotl64(v, 1) & rotl64(v, 8)) ^ rotl64(v, 2);
    endfunction

    // Simon 128/128 key schedule (m = 2, constant sequence z2)
    task automatic set_key(input logic [127:0] key);
        logic [63:0] z;
        z = 64'h7369f885192c0ef5;
        rk_tbl[0] = key[63:0];
        rk_tbl[1] = key[127:64];
        for (int i = 0; i < NR - 2; i++) begin
            rk_tbl[i+2] = 64'hffff_ffff_ffff_fffc ^ {63'd0, z[i % 62]} ^ rk_tbl[i]
                          ^ rotr64(rk_tbl[i+1], 3) ^ rotr64(rk_tbl[i+1], 4);
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] t;
        x = p[127:64];
        y = p[63:0];
        for (int i = 0; i < NR; i++) begin
            t = x;
            x = y ^ ff(x) ^ rk_tbl[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge with the core idle; returns at the negedge where out_valid is first seen
    task automatic run_block(input logic [127:0] ct, output int lat, output int idx_seq[$]);
        in_valid = 1'b1;
        ct_in    = ct;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        idx_seq.delete();
        while (!out_valid && lat < 300) begin
            idx_seq.push_back(int'(rk_idx));
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_output();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seq[$];
        logic [127:0] pt;
        logic [127:0] held;
        logic [127:0] key;
        int n;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        ct_in     = rand128();
`ifdef SIMON_DEC_ABORT_EN
        abort     = 1'b0;
`endif
        for (int i = 0; i < 128; i++) rk_tbl[i] = 64'd0;

        // Reset with a pending block: nothing may load
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check_val("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check_val("rst_busy", {127'd0, busy}, 128'd0);
        check_val("rst_pt", pt_out, 128'd0);
        check_val("rst_rk_idx", {121'd0, rk_idx}, 128'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        // Known answer
        set_key(128'h0f0e0d0c0b0a09080706050403020100);
        check_val("kat_model", encrypt(128'h63736564207372656c6c657661727420),
                  128'h49681b1e1e54fe3f65aa832af84e0bbc);
        run_block(128'h49681b1e1e54fe3f65aa832af84e0bbc, lat, seq);
        check_val("kat_latency", 128'(lat), 128'(NR));
        check_val("kat_pt", pt_out, 128'h63736564207372656c6c657661727420);
        check_val("kat_idx_count", 128'(seq.size()), 128'(NR));
        for (int i = 0; i < seq.size() && i < NR; i++)
            check_val("kat_idx_seq", 128'(seq[i]), 128'(NR - 1 - i));
        check_val("kat_done_rk_idx", {121'd0, rk_idx}, 128'd0);
        check_val("kat_done_in_ready", {127'd0, in_ready}, 128'd0);
        take_output();
        check_val("kat_back_idle", {127'd0, in_ready}, 128'd1);
        check_val("kat_out_valid_drop", {127'd0, out_valid}, 128'd0);

        // Random round trips
        for (int b = 0; b < 16; b++) begin
            key = rand128();
            set_key(key);
            pt = rand128();
            run_block(encrypt(pt), lat, seq);
            check_val("rt_latency", 128'(lat), 128'(NR));
            check_val("rt_pt", pt_out, pt);
            take_output();
        end

        // Backpressure in DONE with new blocks offered
        pt = rand128();
        run_block(encrypt(pt), lat, seq);
        held = pt_out;
        check_val("bp_pt", held, pt);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            ct_in    = rand128();
            @(negedge clk);
            check_val("bp_pt_stable", pt_out, pt);
            check_val("bp_in_ready", {127'd0, in_ready}, 128'd0);
            check_val("bp_out_valid", {127'd0, out_valid}, 128'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("bp_release_idle", {127'd0, in_ready}, 128'd1);
        check_val("bp_release_valid", {127'd0, out_valid}, 128'd0);
        check_val("bp_no_load", pt_out, pt);

        // Reset in the middle of a run
        pt = rand128();
        in_valid = 1'b1;
        ct_in    = encrypt(pt);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        check_val("mid_busy", {127'd0, busy}, 128'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
        check_val("mid_rst_busy", {127'd0, busy}, 128'd0);
        check_val("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        check_val("mid_rst_pt", pt_out, 128'd0);
        check_val("mid_rst_rk_idx", {121'd0, rk_idx}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pt = rand128();
        run_block(encrypt(pt), lat, seq);
        check_val("after_rst_pt", pt_out, pt);
        take_output();

`ifdef SIMON_DEC_ABORT_EN
        // Abort in RUN at idx 10
        pt = rand128();
        in_valid = 1'b1;
        ct_in    = encrypt(pt);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 7'd10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_reach_idx10", {121'd0, rk_idx}, 128'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_run_idle", {127'd0, in_ready}, 128'd1);
        check_val("abort_run_rk_idx", {121'd0, rk_idx}, 128'd0);
        check_val("abort_run_pt", pt_out, 128'd0);
        n = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check_val("abort_run_no_valid", 128'(n), 128'd0);

        // Abort together with output handshake in DONE
        pt = rand128();
        run_block(encrypt(pt), lat, seq);
        check_val("abort_done_pt", pt_out, pt);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        check_val("abort_done_valid", {127'd0, out_valid}, 128'd0);
        check_val("abort_done_idle", {127'd0, in_ready}, 128'd1);
        check_val("abort_done_pt_clr", pt_out, 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_dec_core.md
# simon_dec_core

Iterative Simon 128/128 decryption core: the inverse of the Simon encryption round datapath. It accepts one 128-bit ciphertext block through a valid/ready handshake and runs ROUNDS inverse rounds, one per cycle. Round keys are requested in reverse order through an index port and come from the external key store. It presents the 128-bit plaintext through a second valid/ready handshake, and sits beside the encryption round in the cipher datapath.

## Interface
- ROUNDS, 68, number of inverse rounds executed; legal range 1..128.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high; all registers clear while high.
- in_valid_i  in  1  ciphertext present on ct_i.
- in_ready_o  out  1  core can accept a block; high only in IDLE.
- ct_i  in  128  ciphertext block; x = ct_i[127:64], y = ct_i[63:0].
- rk_idx_o  out  7  index of the round key needed this cycle; counts ROUNDS-1 down to 0.
- kj_i  in  64  round key for rk_idx_o; combinational response, valid in the same cycle.
- out_valid_o  out  1  plaintext valid on pt_o.
- out_ready_i  in  1  consumer accepts pt_o.
- pt_o  out  128  plaintext block {x, y}; driven directly from the state register.
- busy_o  out  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE (enum); reset state IDLE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: load {x, y} <= ct_i, load idx <= ROUNDS-1, then go to RUN.
- RUN, one inverse round per cycle:
  - f(v) = (rotl(v,1) & rotl(v,8)) ^ rotl(v,2).
  - Update: x' = y, y' = x ^ f(y) ^ kj_i.
  - When idx==0, the round is performed and the FSM goes to DONE; otherwise idx <= idx-1.
  - in_valid_i is ignored; ct_i is not sampled.
- DONE:
  - out_valid_o=1.
  - pt_o and idx are held stable.
  - On out_valid_o & out_ready_i: go to IDLE.
- rk_idx_o always equals the idx register. It holds 0 after completion until the next load.
- Inverse round correctness: enc(x,y) = (y ^ f(x) ^ k, x), so dec(enc(x,y)) = (x,y) under the same k.

## Timing
- Reset values:
  - in_ready_o=1 (state IDLE); handshakes are ignored while rst is high.
  - out_valid_o=0, busy_o=0, pt_o=0, rk_idx_o=0.
- Latency: the acceptance edge is E0; rounds are performed at edges E1..E_ROUNDS.
  - out_valid_o rises after E_ROUNDS, i.e. ROUNDS cycles after acceptance.
- Throughput: one block per ROUNDS+2 cycles when out_ready_i is held high (accept, ROUNDS rounds, output).
- A DONE→IDLE edge and a new acceptance never coincide: in_ready_o=0 in DONE.
- Backpressure: out_ready_i low holds DONE indefinitely with pt_o stable.
- Reset mid-operation: FSM returns to IDLE immediately and all registers clear; the in-flight block is discarded.
- ROUNDS=1: a single RUN cycle with rk_idx_o=0, then DONE.

## Configuration
- Macro: SIMON_DEC_ABORT_EN.
- Defined:
  - Adds port abort_i (in, 1).
  - When abort_i is high in RUN or DONE, the next edge goes to IDLE and clears x, y and idx to 0; out_valid_o drops.
  - Abort wins over a simultaneous output handshake; abort_i is ignored in IDLE.
- Undefined: the port is absent, and RUN/DONE exit only via completion and handshake or via rst.

## Structure
- Shared package simon_pkg holds:
  - SIMON_WORD=64, SIMON_BLOCK=128, SIMON128_ROUNDS=68.
  - The state enum simon_dec_state_t (IDLE, RUN, DONE).
  - The function simon_f(v) for the round function, shared with the encryption round.
- Sub-module simon_round_inv (combinational): inputs x, y, k; outputs x', y'. It is instantiated once in the core.
- The core holds the FSM, the idx counter and the x/y registers.

## Test plan
- Reset: assert rst with in_valid_i=1 -> in_ready_o=1, out_valid_o=0, pt_o=0, rk_idx_o=0; no load occurs.
- Known answer:
  - Setup: ct_i=49681b1e1e54fe3f65aa832af84e0bbc; the bench key-schedule model for key 0f0e0d0c0b0a09080706050403020100 drives kj_i from rk_idx_o.
  - Expect: out_valid_o rises exactly 68 cycles after acceptance; pt_o=63736564207372656c6c657661727420.
  - Expect: rk_idx_o sequence 67..0 during RUN.
- Round trip: encrypt 16 random blocks with the encryption round model and random keys, then decrypt -> every pt_o equals the original block.
- Backpressure: hold out_ready_i=0 for 20 cycles in DONE, with in_valid_i=1 and changing ct_i -> pt_o stable, in_ready_o=0, no new load. Release -> IDLE the next cycle.
- Reset mid-run: assert rst at round 30 -> immediate IDLE, all outputs at reset values. The next block decrypts correctly.
- SIMON_DEC_ABORT_EN:
  - abort_i pulse in RUN at idx=10 -> IDLE next edge, rk_idx_o=0, out_valid_o never rises.
  - abort_i together with out_ready_i in DONE -> IDLE with state cleared.
